// File: rtl/lsu_if.sv
// CPU request/response and data-memory signal bundle for the load/store unit.
// The slave view is the LSU; the master view is the CPU plus data memory.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  err_cnt;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, err_cnt,
               mem_addr, mem_wdata, mem_write, mem_read
    );

    modport master (
        output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_cnt,
               mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/lsu.sv
// Single-request load/store unit: 16-bit word and byte accesses to a word-wide
// data memory, byte stores done as read-modify-write, misaligned words rejected.
module lsu (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_r, state_s;

    logic        wr_r;
    logic        byte_r;
    logic        sgn_r;
    logic [15:0] addr_r;
    logic [7:0]  wbyte_r;

    logic        accept_s;
    logic        misalign_s;

    logic        ready_r,     ready_s;
    logic        rsp_valid_r, rsp_valid_s;
    logic        rsp_err_r,   rsp_err_s;
    logic [15:0] rsp_rdata_r, rsp_rdata_s;
    logic        mem_read_r,  mem_read_s;
    logic        mem_write_r, mem_write_s;
    logic [15:0] mem_addr_r,  mem_addr_s;
    logic [15:0] mem_wdata_r, mem_wdata_s;
    logic [7:0]  err_cnt_r;

    // Replace one little-endian byte lane of a word.
    function automatic logic [15:0] lane_merge(input logic [15:0] word,
                                               input logic [7:0]  data,
                                               input logic        hi);
        logic [15:0] res;
        if (hi) begin
            res = {data, word[7:0]};
        end else begin
            res = {word[15:8], data};
        end
        return res;
    endfunction

    // Select and extend load data to the 16-bit result.
    function automatic logic [15:0] load_extend(input logic [15:0] word,
                                                input logic        is_byte,
                                                input logic        is_signed,
                                                input logic        hi);
        logic [7:0]  lane;
        logic [15:0] res;
        lane = hi ? word[15:8] : word[7:0];
        if (!is_byte) begin
            res = word;
        end else if (is_signed) begin
            res = {{8{lane[7]}}, lane};
        end else begin
            res = {8'h00, lane};
        end
        return res;
    endfunction

    assign accept_s   = bus.req_valid && ready_r;
    assign misalign_s = !bus.req_byte && bus.req_addr[0];

    // Next state plus the next value of every registered output. The outputs are
    // computed one cycle early so they are flops that match the state they belong to.
    always_comb begin
        state_s     = state_r;
        rsp_rdata_s = 16'h0000;
        rsp_err_s   = 1'b0;
        mem_addr_s  = 16'h0000;
        mem_wdata_s = 16'h0000;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    state_s = IDLE;
                end else if (misalign_s) begin
                    state_s   = RESP;
                    rsp_err_s = 1'b1;
                end else if (bus.req_write && !bus.req_byte) begin
                    state_s     = WRITE;
                    mem_addr_s  = bus.req_addr;
                    mem_wdata_s = bus.req_wdata;
                end else begin
                    state_s    = READ;
                    mem_addr_s = bus.req_addr;
                end
            end
            READ: begin
                // Only byte stores and loads reach READ; the store merges into the read word.
                if (wr_r) begin
                    state_s     = WRITE;
                    mem_addr_s  = addr_r;
                    mem_wdata_s = lane_merge(bus.mem_rdata, wbyte_r, addr_r[0]);
                end else begin
                    state_s     = RESP;
                    rsp_rdata_s = load_extend(bus.mem_rdata, byte_r, sgn_r, addr_r[0]);
                end
            end
            WRITE: begin
                state_s = RESP;
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        ready_s     = (state_s == IDLE);
        rsp_valid_s = (state_s == RESP);
        mem_read_s  = (state_s == READ);
        mem_write_s = (state_s == WRITE);
    end

    // State and output registers; reset clears everything at once, aborting any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 16'h0000;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= 16'h0000;
            mem_wdata_r <= 16'h0000;
        end else begin
            state_r     <= state_s;
            ready_r     <= ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_err_r   <= rsp_err_s;
            rsp_rdata_r <= rsp_rdata_s;
            mem_read_r  <= mem_read_s;
            mem_write_r <= mem_write_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    // Request capture; fields presented while busy are never sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_r    <= 1'b0;
            byte_r  <= 1'b0;
            sgn_r   <= 1'b0;
            addr_r  <= 16'h0000;
            wbyte_r <= 8'h00;
        end else if (accept_s) begin
            wr_r    <= bus.req_write;
            byte_r  <= bus.req_byte;
            sgn_r   <= bus.req_signed;
            addr_r  <= bus.req_addr;
            wbyte_r <= bus.req_wdata[7:0];
        end
    end

    // Saturating error counter, stepped at the end of each error response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_r <= 8'h00;
        end else if (rsp_err_r && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end
    end

    assign bus.req_ready = ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.err_cnt   = err_cnt_r;
    assign bus.mem_read  = mem_read_r;
    assign bus.mem_write = mem_write_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 req_valid  input  1  CPU request present.
REQ-004 req_ready  output  1  LSU can accept a request this cycle.
REQ-005 req_write  input  1  1 = store, 0 = load.
REQ-006 req_byte  input  1  1 = byte access, 0 = 16-bit word access.
REQ-007 req_signed  input  1  byte loads: 1 = sign-extend, 0 = zero-extend; ignored otherwise.
REQ-008 req_addr  input  16  byte address.
REQ-009 req_wdata  input  16  store data; byte stores use bits [7:0].
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  16  load result; 0 when rsp_valid low, and for stores and errors.
REQ-012 rsp_err  output  1  misaligned word access; valid with rsp_valid, else 0.
REQ-013 err_cnt  output  8  saturating count of error responses.
REQ-014 mem_addr  output  16  byte address to data memory; memory indexes words with mem_addr[15:1].
REQ-015 mem_wdata  output  16  word written to data memory.
REQ-016 mem_write  output  1  memory writes mem_wdata on rising edge when high.
REQ-017 mem_read  output  1  memory read enable.
REQ-018 mem_rdata  input  16  asynchronous read data, valid in the same cycle mem_read is high; 0 otherwise.

Function
REQ-019 FSM states SHALL be IDLE, READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1, capturing all req_* fields into registers.
REQ-021 On acceptance, a word access with req_addr[0]=1 SHALL go IDLE->RESP without any memory access.
REQ-022 On acceptance, any other load or a byte store SHALL go to READ; an aligned word store SHALL go to WRITE.
REQ-023 In READ, mem_read SHALL be 1 and mem_addr SHALL be the captured address; mem_rdata SHALL be registered at the end of the cycle.
REQ-024 After READ, a load SHALL go to RESP and a byte store SHALL go to WRITE.
REQ-025 In WRITE, mem_write SHALL be 1 for exactly that one cycle; next state SHALL be RESP.
REQ-026 Word store data SHALL be captured req_wdata; byte store data SHALL be the READ word with the addressed lane replaced by req_wdata[7:0].
REQ-027 Lane select SHALL be little-endian: addr[0]=0 -> bits [7:0], addr[0]=1 -> bits [15:8].
REQ-028 In RESP, rsp_valid SHALL be 1 for one cycle, then the FSM SHALL return to IDLE; there is no response backpressure.
REQ-029 Response data SHALL be: word load = full word; byte load = selected lane, extended per req_signed to 16 bits.
REQ-030 rsp_err SHALL be 1 in RESP only for misaligned word accesses; on that RESP cycle err_cnt SHALL increment, saturating at 255.
REQ-031 Latency from the acceptance edge N SHALL be:
- misaligned: RESP in cycle N+1
- load or word store: RESP in N+2
- byte store: READ N+1, WRITE N+2, RESP N+3
REQ-032 mem_read and mem_write SHALL be 0 outside READ and WRITE respectively, and never both 1; mem_addr and mem_wdata SHALL be 0 in IDLE.
REQ-033 Inputs arriving while req_ready=0 SHALL be ignored; req_valid held high SHALL be accepted on the first cycle back in IDLE.

Reset
REQ-034 While rst=1, outputs SHALL be: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, err_cnt=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-035 Reset asserted mid-operation SHALL abort immediately: no pending write is performed and no response is issued.

Verification
Preload word index 8 (byte address 0x0010) = 0xA5F3 in all scenarios.
REQ-036 Word load, addr 0x0010, accepted at N -> rsp_valid at N+2, rsp_rdata=0xA5F3, rsp_err=0.
REQ-037 Byte load, signed, addr 0x0011 -> rsp_rdata=0xFFA5; byte load, unsigned, addr 0x0010 -> rsp_rdata=0x00F3.
REQ-038 Byte store, addr 0x0011, wdata 0x123C -> mem_write high only at N+2 with mem_wdata=0x3CF3, rsp_valid at N+3; a subsequent word load returns 0x3CF3.
REQ-039 Word store, addr 0x0013 -> rsp_err=1 at N+1, mem_write never high, err_cnt 0->1; after 300 such errors, err_cnt=255.
REQ-040 rst pulsed during READ of a byte store to 0x0010 -> all outputs at reset values within the same cycle; memory word stays 0xA5F3; req_ready=1 after release.
REQ-041 Two loads back-to-back with req_valid held high -> req_ready=0 from N+1 to N+2, second request accepted at N+3, responses in request order.
